toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive side of a toggle-signalling link; the sender is a T flip-flop whose output flips once per event.
- Synchronises the incoming toggle level and decodes each level change into a one-cycle event pulse.
- Buffers pending events in a saturating counter, presented through a valid/ready interface.
- Returns an acknowledge toggle to the sender, one flip per consumed event.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tog_in; legal range 2..4.
- CNT_W, 4, width of the pending-event counter; maximum pending count is 2^CNT_W-1.
- FILTER_CYCLES, 3, consecutive cycles a new level must persist before acceptance; used only with TOGGLE_DEBOUNCE_EN; legal range 2..15.

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- tog_in  input  1  toggle line from the remote T flip-flop; asynchronous to clk
- evt_pulse  output  1  registered one-cycle pulse per accepted toggle
- evt_valid  output  1  high while pending != 0
- evt_ready  input  1  consumer accepts one event when evt_valid && evt_ready
- pending  output  CNT_W  number of buffered, unconsumed events
- overflow  output  1  sticky; an event arrived while pending was at maximum
- overflow_clr  input  1  synchronous clear of overflow
- ack_tog  output  1  flips once per consumed event

Behaviour:
- Reset (clear_n low, asynchronous): all sync flops, tog_prev, arm counter, pending, overflow, ack_tog, evt_pulse = 0. evt_valid = 0.
- Synchroniser: SYNC_STAGES-flop chain on tog_in; tog_sync = last stage.
- Arming:
  - After clear_n deasserts, a counter runs SYNC_STAGES cycles; armed goes high on completion.
  - While not armed: tog_prev <= tog_sync every cycle and no events are generated.
  - A tog_in held at 1 through reset therefore produces no spurious event.
- Detection (armed):
  - change = tog_sync != tog_prev.
  - On acceptance: tog_prev <= tog_sync and evt_pulse <= 1 for exactly one cycle.
  - Latency: tog_in changes before clk edge N; evt_pulse is high in the cycle following edge N+SYNC_STAGES.
  - Back-to-back toggles 1 cycle apart produce back-to-back pulses.
  - A double toggle narrower than one clk period may be lost; this is a sender rule violation and is not detected.
- Pending counter, per cycle:
  - inc = evt_pulse; dec = evt_valid && evt_ready.
  - inc && dec: pending unchanged.
  - inc only: pending+1. At maximum, pending holds and overflow <= 1 (the event is dropped).
  - dec only: pending-1. dec is impossible at 0, since evt_valid = 0 there.
- evt_valid = (pending != 0); purely from registered state, with no combinational path from evt_ready.
- overflow: overflow_clr clears it next cycle. When a set and overflow_clr occur in the same cycle, the set wins.
- ack_tog: flips on every cycle where evt_valid && evt_ready. Reset value is 0.
- Reset mid-operation: all state is discarded immediately, including pending events and sticky overflow. Re-arming then follows the arming rule above.

Optional Feature:
- Macro: TOGGLE_DEBOUNCE_EN.
- Defined:
  - A 4-bit stability counter increments each cycle change = 1 and clears when change = 0.
  - Acceptance happens on the FILTER_CYCLES-th consecutive cycle of change = 1; the counter then clears.
  - Latency becomes SYNC_STAGES+FILTER_CYCLES-1 cycles.
  - Glitches shorter than FILTER_CYCLES cycles produce no event.
- Undefined: no stability counter; acceptance on the first cycle of change = 1. The FILTER_CYCLES value is ignored.

Test Plan:
- Single toggle:
  - Stimulus: reset, wait 4 cycles, tog_in 0->1 before edge N, evt_ready=0.
  - Response: evt_pulse high only in the cycle after edge N+2; pending=1; evt_valid=1; ack_tog=0.
- Consume:
  - Stimulus: from pending=1, evt_ready=1 for one cycle.
  - Response: pending=0, evt_valid=0, ack_tog=1. A second toggle and consume brings ack_tog back to 0.
- Simultaneous inc/dec:
  - Stimulus: pending=3, evt_ready held 1 while one toggle arrives.
  - Response: pending stays 3 on the pulse cycle and decrements on the other cycles.
- Overflow:
  - Stimulus: evt_ready=0, 16 toggles spaced 4 cycles apart.
  - Response: pending saturates at 15; overflow=1 after the 16th pulse.
  - Then overflow_clr together with a 17th pulse in the same cycle: overflow stays 1. overflow_clr alone: overflow=0.
- Reset behaviour:
  - Stimulus: tog_in=1 held through clear_n low->high.
  - Response: no evt_pulse and pending=0. Asserting clear_n low mid-stream with pending=5 gives pending=0, evt_valid=0 asynchronously.
- Debounce (TOGGLE_DEBOUNCE_EN, FILTER_CYCLES=3):
  - A 2-cycle tog_in pulse gives no event.
  - A held toggle gives evt_pulse in the cycle after edge N+4.

Source files
------------

// File: rtl/toggle_event_decoder_if.sv
// Event handshake between toggle_event_decoder (master) and its consumer (slave).
// The master presents the pending-event count and a valid flag. The slave
// takes one event on every cycle where it holds evt_ready high while
// evt_valid is high.
interface toggle_event_decoder_if #(
    parameter int CNT_W = 4
);
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] pending;

    modport master (
        output evt_valid,
        output pending,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  pending,
        output evt_ready
    );
endinterface

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: receive side of a toggle-signalling link.
// The incoming toggle level is synchronised, and each level change becomes a
// one-cycle event pulse. Events are buffered in a saturating pending counter
// and presented through a valid/ready handshake. One ack toggle is returned
// for each consumed event.
//
// Optional build macro TOGGLE_DEBOUNCE_EN: a new level must persist for
// FILTER_CYCLES consecutive cycles before it is accepted. Without the macro,
// a level change is accepted on the first cycle it is seen.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ARMING  | after reset; tog_prev shadows tog_sync, no events generated
// ST_ARMED   | normal operation; level changes are decoded into events
module toggle_event_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 4,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                           clk,
    input  logic                           clear_n,
    input  logic                           tog_in,
    output logic                           evt_pulse,
    output logic                           overflow,
    input  logic                           overflow_clr,
    output logic                           ack_tog,
    toggle_event_decoder_if.master         evt_if
);

    // The chain needs SYNC_STAGES edges to flush the reset value.
    // tog_prev needs one more edge to capture the settled level, so the arm
    // counter stops when it reaches SYNC_STAGES.
    localparam logic [2:0]       ARM_LAST = 3'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("toggle_event_decoder: SYNC_STAGES must be 2..4");
    end
    if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_bad_filter
        $error("toggle_event_decoder: FILTER_CYCLES must be 2..15");
    end

    typedef enum logic {
        ST_ARMING = 1'b0,
        ST_ARMED  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   armed;
    logic [2:0]             arm_cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tog_sync;
    logic                   tog_prev;
    logic                   change;
    logic                   accept;
    logic [CNT_W-1:0]       pending_q;
    logic                   inc;
    logic                   dec;
    logic                   ovf_set;

    assign tog_sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chain on the asynchronous toggle line.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
        end
    end

    // Arming FSM state register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_ARMING;
        end else begin
            state_q <= state_d;
        end
    end

    // Arming FSM next state and the armed qualifier.
    always_comb begin
        state_d = state_q;
        armed   = 1'b0;
        case (state_q)
            ST_ARMING: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                armed = 1'b1;
            end
            default: begin
                state_d = ST_ARMING;
            end
        endcase
    end

    // Arm counter: counts the edges after reset release while arming, then holds.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            arm_cnt_q <= '0;
        end else if (state_q == ST_ARMING && arm_cnt_q != ARM_LAST) begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
        end
    end

    assign change = armed && (tog_sync != tog_prev);

`ifdef TOGGLE_DEBOUNCE_EN
    localparam logic [3:0] FILTER_LAST = 4'(FILTER_CYCLES - 1);

    logic [3:0] stab_cnt_q;

    // A change is accepted only on its FILTER_CYCLES-th consecutive cycle.
    assign accept = change && (stab_cnt_q == FILTER_LAST);

    // Stability counter: counts consecutive cycles of change and restarts after acceptance.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            stab_cnt_q <= '0;
        end else if (!change || accept) begin
            stab_cnt_q <= '0;
        end else begin
            stab_cnt_q <= stab_cnt_q + 4'd1;
        end
    end
`else
    assign accept = change;
`endif

    // Reference level: shadows the sync output until armed, then follows accepted changes.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            tog_prev <= 1'b0;
        end else if (!armed || accept) begin
            tog_prev <= tog_sync;
        end
    end

    // One-cycle registered event pulse.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            evt_pulse <= 1'b0;
        end else begin
            evt_pulse <= accept;
        end
    end

    assign evt_if.pending   = pending_q;
    assign evt_if.evt_valid = (pending_q != '0);

    assign inc     = evt_pulse;
    assign dec     = evt_if.evt_valid && evt_if.evt_ready;
    assign ovf_set = inc && !dec && (pending_q == PEND_MAX);

    // Pending counter: saturates at its maximum and drops the extra event.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pending_q <= '0;
        end else if (inc && !dec && pending_q != PEND_MAX) begin
            pending_q <= pending_q + 1'b1;
        end else if (dec && !inc) begin
            pending_q <= pending_q - 1'b1;
        end
    end

    // Sticky overflow flag: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // Acknowledge toggle: flips once per consumed event.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ack_tog <= 1'b0;
        end else if (dec) begin
            ack_tog <= ~ack_tog;
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Randomized self-checking bench for toggle_event_decoder.
// The reference model tracks the level the detector sees, delayed by the
// synchroniser depth. It also tracks the last accepted level, a queue of
// pending events, the sticky overflow flag and the ack parity.
// Build with TOGGLE_DEBOUNCE_EN defined to check the debounce variant.
module tb_toggle_event_decoder;

    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W         = 4;
    localparam int FILTER_CYCLES = 3;
    localparam int PEND_MAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic clear_n;
    logic tog_in;
    logic evt_pulse;
    logic overflow;
    logic overflow_clr;
    logic ack_tog;

    toggle_event_decoder_if #(.CNT_W(CNT_W)) evt_if ();

    toggle_event_decoder #(
        .SYNC_STAGES  (SYNC_STAGES),
        .CNT_W        (CNT_W),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .tog_in      (tog_in),
        .evt_pulse   (evt_pulse),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .ack_tog     (ack_tog),
        .evt_if      (evt_if.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit pipe[$];
    int m_edges;
    bit m_ref;
    int m_run;
    bit m_pulse;
    int m_pend;
    bit m_ovf;
    bit m_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back(1'b0);
        m_edges = 0;
        m_ref   = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        m_ack   = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held before the edge.
    task automatic m_edge(input bit tin, input bit rdy, input bit clr);
        bit seen;
        bit new_pulse;
        bit dec;
        bit inc;
        bit set;
        seen = pipe.pop_front();
        pipe.push_back(tin);
        m_edges++;
        new_pulse = 1'b0;
        if (m_edges < SYNC_STAGES + 2) begin
            m_ref = seen;
            m_run = 0;
        end else if (seen != m_ref) begin
`ifdef TOGGLE_DEBOUNCE_EN
            m_run++;
            if (m_run == FILTER_CYCLES) begin
                new_pulse = 1'b1;
                m_ref     = seen;
                m_run     = 0;
            end
`else
            new_pulse = 1'b1;
            m_ref     = seen;
`endif
        end else begin
            m_run = 0;
        end
        inc = m_pulse;
        dec = (m_pend != 0) && rdy;
        set = 1'b0;
        if (inc && !dec) begin
            if (m_pend == PEND_MAX) set = 1'b1;
            else m_pend++;
        end else if (dec && !inc) begin
            m_pend--;
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (dec) m_ack = ~m_ack;
        m_pulse = new_pulse;
    endtask

    task automatic check_all(input string where);
        chk({where, ":evt_pulse"}, 32'(evt_pulse), 32'(m_pulse));
        chk({where, ":pending"},   32'(evt_if.pending), 32'(m_pend));
        chk({where, ":evt_valid"}, 32'(evt_if.evt_valid), 32'(m_pend != 0));
        chk({where, ":overflow"},  32'(overflow), 32'(m_ovf));
        chk({where, ":ack_tog"},   32'(ack_tog), 32'(m_ack));
    endtask

    // Advance one cycle, update the model and compare 1 time unit after the edge.
    task automatic step(input string where);
        bit tin;
        bit rdy;
        bit clr;
        bit rst_low;
        tin     = tog_in;
        rdy     = evt_if.evt_ready;
        clr     = overflow_clr;
        rst_low = !clear_n;
        @(posedge clk);
        if (!rst_low) m_edge(tin, rdy, clr);
        #1;
        check_all(where);
    endtask

    task automatic rand_phase(input string where, input int cycles, input int tog_mod);
        int rdy_pct;
        rdy_pct = 50;
        for (int c = 0; c < cycles; c++) begin
            if (c % 64 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, tog_mod - 1) == 0) tog_in = ~tog_in;
            evt_if.evt_ready = ($urandom_range(0, 99) < rdy_pct);
            overflow_clr     = ($urandom_range(0, 15) == 0);
            step(where);
        end
    endtask

    initial begin
        clear_n          = 1'b1;
        tog_in           = 1'b1;
        evt_if.evt_ready = 1'b0;
        overflow_clr     = 1'b0;
        m_reset();
        #2;
        clear_n = 1'b0;
        #1;
        check_all("reset");
        for (int i = 0; i < 3; i++) step("in_reset");
        clear_n = 1'b1;
        for (int i = 0; i < 12; i++) step("held_high");
        chk("held_high_no_event", 32'(evt_if.pending), 32'd0);

        tog_in = 1'b0;
        for (int i = 0; i < 8; i++) step("single");
        chk("single_pending", 32'(evt_if.pending), 32'd1);
        evt_if.evt_ready = 1'b1;
        step("consume");
        evt_if.evt_ready = 1'b0;
        chk("consume_ack", 32'(ack_tog), 32'd1);
        step("consume_idle");

        rand_phase("rand_fast", 1500, 3);
        rand_phase("rand_slow", 1500, 8);

        evt_if.evt_ready = 1'b0;
        overflow_clr     = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tog_in = ~tog_in;
            for (int s = 0; s < 6; s++) begin
                step("ovf_fill");
                overflow_clr = (t >= 17) ? m_pulse : 1'b0;
            end
        end
        overflow_clr = 1'b0;
        chk("ovf_sat_pending", 32'(evt_if.pending), 32'(PEND_MAX));
        chk("ovf_sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        step("ovf_clr");
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) step("drain_part");
        evt_if.evt_ready = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_pending", 32'(evt_if.pending), 32'd0);
        chk("async_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check_all("async_rst");
        for (int i = 0; i < 2; i++) step("mid_reset");
        clear_n = 1'b1;

        rand_phase("rand_after_rst", 2000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
